// File: rtl/led_pwm_driver.sv
// Bus-mapped 4-LED driver: per-LED off/on/blink/PWM modes from shared
// prescaler, PWM and blink counters, behind a four-phase read/write/ack port.

module led_lane (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [7:0] duty,
  input  logic [7:0] pwm_cnt,
  input  logic       blink_phase,
  output logic       led
);
  always_ff @(posedge clock) begin
    if (reset) led <= 1'b0;
    else begin
      unique case (mode)
        2'b00: led <= 1'b0;
        2'b01: led <= 1'b1;
        2'b10: led <= blink_phase;
        2'b11: led <= (pwm_cnt < duty);
      endcase
    end
  end
endmodule

module led_pwm_driver #(
  parameter int          PRESCALE  = 4,
  parameter logic [15:0] BLINK_RST = 16'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        write,
  input  logic        read,
  output logic        ack,
  output logic [3:0]  led_out
);
  localparam int          NUM_LANES = 4;
  localparam logic [15:0] PRE_MAX   = 16'(PRESCALE - 1);

  logic [NUM_LANES-1:0][1:0] mode_q;
  logic [NUM_LANES-1:0][7:0] duty_q;
  logic [15:0]               blink_q;
  logic [15:0]               pre_cnt;
  logic [7:0]                pwm_cnt;
  logic [15:0]               blink_cnt;
  logic                      blink_phase;
  logic                      ack_rise, do_write, do_read, tick, wrap;
  logic [31:0]               rd_data;

  // A transfer is accepted only on the edge where ack rises.
  assign ack_rise = (read | write) & ~ack;
  assign do_write = ack_rise & write;
  assign do_read  = ack_rise & read & ~write;
  assign tick     = (pre_cnt == PRE_MAX);
  assign wrap     = tick & (pwm_cnt == 8'hFF);

  always_ff @(posedge clock) begin
    if (reset) ack <= 1'b0;
    else       ack <= read | write;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q  <= '0;
      duty_q  <= '0;
      blink_q <= BLINK_RST;
    end else if (do_write) begin
      unique case (address)
        2'd0: mode_q  <= data_in[7:0];
        2'd1: duty_q  <= data_in;
        2'd2: blink_q <= data_in[15:0];
        2'd3: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (address)
      2'd0: rd_data = {24'b0, mode_q};
      2'd1: rd_data = duty_q;
      2'd2: rd_data = {16'b0, blink_q};
      2'd3: rd_data = {27'b0, blink_phase, led_out};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)        data_out <= '0;
    else if (do_read) data_out <= rd_data;
  end

  // Counters free-run; a BLINK below blink_cnt lets it run round to 0 first.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      if (wrap) begin
        if (blink_cnt == blink_q) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    led_lane u_lane (
      .clock       (clock),
      .reset       (reset),
      .mode        (mode_q[i]),
      .duty        (duty_q[i]),
      .pwm_cnt     (pwm_cnt),
      .blink_phase (blink_phase),
      .led         (led_out[i])
    );
  end
endmodule
